// File: rtl/scsi_pkg.sv
// Shared definitions for the SCSI target / SD host arbitration slice.
package scsi_pkg;

  localparam int MAX_TARGETS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } scsi_state_e;

endpackage

// File: rtl/scsi_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr (with wrap) wins.
module scsi_rr_pick #(
  parameter int NUM_TARGETS = 2,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_TARGETS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   valid,
  output logic [IDX_W-1:0]       idx
);

  // Rank each requester by its distance past ptr and keep the closest one.
  always_comb begin
    int   dist_s;
    int   best_s;
    logic hit_s;
    dist_s = 0;
    best_s = NUM_TARGETS;
    hit_s  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      dist_s = (i + 2 * NUM_TARGETS - 1 - int'(ptr)) % NUM_TARGETS;
      hit_s  = req[i] && (dist_s < best_s);
      best_s = hit_s ? dist_s : best_s;
      idx    = hit_s ? IDX_W'(i) : idx;
    end
    valid = |req;
  end

endmodule

// File: rtl/scsi_sd_arbiter.sv
// Shares one SD host io channel among NUM_TARGETS SCSI targets, one sector
// transfer at a time, with round-robin fairness between targets.
module scsi_sd_arbiter
  import scsi_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int IDX_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_TARGETS-1:0]    tgt_io_rd,
  input  logic [NUM_TARGETS-1:0]    tgt_io_wr,
  input  logic [32*NUM_TARGETS-1:0] tgt_io_lba,
  output logic [NUM_TARGETS-1:0]    tgt_io_ack,
  input  logic [16*NUM_TARGETS-1:0] tgt_buff_din,
  output logic [NUM_TARGETS-1:0]    tgt_buff_wr,
  output logic [31:0]               sd_lba,
  output logic                      sd_rd,
  output logic                      sd_wr,
  input  logic                      sd_ack,
  input  logic                      sd_buff_wr,
  output logic [15:0]               sd_buff_din,
  output logic [IDX_W-1:0]          grant,
  output logic                      busy
);

  scsi_state_e      state_r;
  logic [IDX_W-1:0] grant_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic             op_wr_r;
  logic [31:0]      sd_lba_r;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_rd_s;
  logic [31:0]      pick_lba_s;
  logic [15:0]      buff_din_s;
  logic             gate_s;

  scsi_rr_pick #(
    .NUM_TARGETS(NUM_TARGETS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req  (tgt_io_rd | tgt_io_wr),
    .ptr  (rr_ptr_r),
    .valid(pick_valid_s),
    .idx  (pick_idx_s)
  );

  // Select the candidate's LBA and read flag, and the granted target's write data.
  always_comb begin
    pick_lba_s = 32'd0;
    pick_rd_s  = 1'b0;
    buff_din_s = 16'd0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      pick_lba_s = pick_lba_s | ((pick_idx_s == IDX_W'(i)) ? tgt_io_lba[32*i +: 32] : 32'd0);
      pick_rd_s  = pick_rd_s  | ((pick_idx_s == IDX_W'(i)) && tgt_io_rd[i]);
      buff_din_s = buff_din_s | ((grant_r == IDX_W'(i)) ? tgt_buff_din[16*i +: 16] : 16'd0);
    end
  end

  // Arbitration FSM; read wins over write when one target asks for both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      grant_r  <= '0;
      rr_ptr_r <= IDX_W'(NUM_TARGETS - 1);
      op_wr_r  <= 1'b0;
      sd_lba_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sd_ack) begin
            state_r <= ST_DRAIN;
          end else if (pick_valid_s) begin
            grant_r  <= pick_idx_s;
            op_wr_r  <= !pick_rd_s;
            sd_lba_r <= pick_lba_s;
            state_r  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd_ack) begin
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!sd_ack) begin
            rr_ptr_r <= grant_r;
            state_r  <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!sd_ack) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-target ack and buffer strobe reach only the granted target during a transfer.
  always_comb begin
    tgt_io_ack  = '0;
    tgt_buff_wr = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      tgt_io_ack[i]  = gate_s && (grant_r == IDX_W'(i)) && sd_ack;
      tgt_buff_wr[i] = gate_s && (grant_r == IDX_W'(i)) && sd_buff_wr;
    end
  end

  assign gate_s      = (state_r == ST_ISSUE) || (state_r == ST_XFER);
  assign sd_rd       = (state_r == ST_ISSUE) && !op_wr_r;
  assign sd_wr       = (state_r == ST_ISSUE) && op_wr_r;
  assign sd_lba      = sd_lba_r;
  assign grant       = grant_r;
  assign busy        = (state_r != ST_IDLE);
  assign sd_buff_din = buff_din_s;

endmodule
